// File: rtl/pktrrarb.sv
// Packet-granular round-robin arbiter: merges NIN packet streams onto one
// registered output, holding each grant for a whole packet, with a stall watchdog.
module pktrrarb #(
  parameter int NIN          = 2,
  parameter int PKTDW        = 128,
  parameter int LGTIMEOUT    = 10,
  parameter bit OPT_LOWPOWER = 1'b0,
  localparam int BW          = $clog2(PKTDW/8),
  localparam int GW          = $clog2(NIN)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NIN-1:0]       S_VALID,
  output logic [NIN-1:0]       S_READY,
  input  logic [NIN*PKTDW-1:0] S_DATA,
  input  logic [NIN*BW-1:0]    S_BYTES,
  input  logic [NIN-1:0]       S_LAST,
  input  logic [NIN-1:0]       S_ABORT,
  output logic                 M_VALID,
  output logic [PKTDW-1:0]     M_DATA,
  output logic [BW-1:0]        M_BYTES,
  output logic                 M_LAST,
  input  logic                 M_READY,
  output logic                 M_ABORT,
  output logic [NIN-1:0]       o_grant,
  output logic                 o_timeout
);

  // Handshake: a beat moves on any edge where VALID && READY are both high;
  // M_VALID holds M_DATA/M_BYTES/M_LAST stable until M_READY is seen.
  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DRAIN} state_t;

  state_t               state, state_n;
  logic [GW-1:0]        grant, grant_n;
  logic [GW-1:0]        last_srv, last_srv_n;
  logic [GW-1:0]        pick, idx;
  logic                 found;
  logic                 started, started_n;
  logic [LGTIMEOUT-1:0] wd, wd_n, wd_inc;

  logic                 m_valid_n, m_last_n, m_abort_n, timeout_n;
  logic [PKTDW-1:0]     m_data_n;
  logic [BW-1:0]        m_bytes_n;

  logic [PKTDW-1:0]     s_data_a  [NIN];
  logic [BW-1:0]        s_bytes_a [NIN];
  logic                 sel_valid, sel_last, sel_abort, out_free;

  for (genvar k = 0; k < NIN; k++) begin : g_unpack
    assign s_data_a[k]  = S_DATA[k*PKTDW +: PKTDW];
    assign s_bytes_a[k] = S_BYTES[k*BW +: BW];
  end

  assign sel_valid = S_VALID[grant];
  assign sel_last  = S_LAST[grant];
  assign sel_abort = S_ABORT[grant];
  assign out_free  = !M_VALID || M_READY;
  assign wd_inc    = wd + 1'b1;

  // First valid source searching upward from the one served last.
  always_comb begin
    pick  = last_srv;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NIN; i++) begin
      idx = GW'((int'(last_srv) + i) % NIN);
      if (!found && S_VALID[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    S_READY = '0;
    o_grant = '0;
    if (state != ST_IDLE) o_grant[grant] = 1'b1;
    if (state == ST_PKT)   S_READY[grant] = !sel_abort && out_free;
    if (state == ST_DRAIN) S_READY[grant] = 1'b1;
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    last_srv_n = last_srv;
    started_n  = started;
    wd_n       = wd;
    m_valid_n  = M_VALID && !M_READY;
    m_data_n   = M_DATA;
    m_bytes_n  = M_BYTES;
    m_last_n   = M_LAST;
    m_abort_n  = 1'b0;
    timeout_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_n   = pick;
          state_n   = ST_PKT;
          started_n = 1'b0;
          wd_n      = '0;
        end
      end
      ST_PKT: begin
        if (sel_abort) begin
          // An abort before any beat is invisible downstream.
          state_n    = ST_IDLE;
          last_srv_n = grant;
          if (started) begin
            m_abort_n = 1'b1;
            m_valid_n = 1'b0;
          end
        end else if (sel_valid && out_free) begin
          m_valid_n = 1'b1;
          m_data_n  = s_data_a[grant];
          m_bytes_n = s_bytes_a[grant];
          m_last_n  = sel_last;
          started_n = 1'b1;
          wd_n      = '0;
          if (sel_last) begin
            state_n    = ST_IDLE;
            last_srv_n = grant;
          end
        end else if (started && !sel_valid) begin
          wd_n = wd_inc;
          if (wd_inc == '1) begin
            m_abort_n = 1'b1;
            timeout_n = 1'b1;
            m_valid_n = 1'b0;
            state_n   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (sel_abort || (sel_valid && sel_last)) begin
          state_n    = ST_IDLE;
          last_srv_n = grant;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (OPT_LOWPOWER && !m_valid_n) begin
      m_data_n  = '0;
      m_bytes_n = '0;
      m_last_n  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      last_srv  <= GW'(NIN-1);
      started   <= 1'b0;
      wd        <= '0;
      M_VALID   <= 1'b0;
      M_DATA    <= '0;
      M_BYTES   <= '0;
      M_LAST    <= 1'b0;
      M_ABORT   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      last_srv  <= last_srv_n;
      started   <= started_n;
      wd        <= wd_n;
      M_VALID   <= m_valid_n;
      M_DATA    <= m_data_n;
      M_BYTES   <= m_bytes_n;
      M_LAST    <= m_last_n;
      M_ABORT   <= m_abort_n;
      o_timeout <= timeout_n;
    end
  end

endmodule

// File: doc/pktrrarb.md
# pktrrarb

Round-robin, packet-granular arbiter that shares one outgoing network packet stream between NIN packet sources, e.g. the CPU transmit stream and a second internal packet generator feeding the same outgoing port. The grant is held from a packet's first beat until its LAST or ABORT. Aborts are forwarded. A stall watchdog aborts and drains a granted source that stops delivering mid-packet. The output is a single registered stage with full one-beat-per-cycle throughput.

## Interface
- NIN, 2: number of input packet streams (≥2).
- PKTDW, 128: packet data width in bits.
- LGTIMEOUT, 10: watchdog width; timeout after 2^LGTIMEOUT-1 consecutive mid-packet cycles with S_VALID[g] low.
- OPT_LOWPOWER, 0: when 1, M_DATA/M_BYTES/M_LAST are zeroed whenever M_VALID is 0.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- S_VALID  in  NIN  per-source beat valid.
- S_READY  out  NIN  per-source beat accept.
- S_DATA  in  NIN*PKTDW  per-source data, source k at [k*PKTDW +: PKTDW].
- S_BYTES  in  NIN*$clog2(PKTDW/8)  per-source byte count, same packing; passed through unchanged.
- S_LAST  in  NIN  last beat of packet.
- S_ABORT  in  NIN  source abandons current packet.
- M_VALID, M_DATA, M_BYTES, M_LAST  out  1/PKTDW/$clog2(PKTDW/8)/1  merged stream.
- M_READY  in  1  downstream accept.
- M_ABORT  out  1  merged-stream abort.
- o_grant  out  NIN  one-hot current grant (0 in IDLE).
- o_timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, PKT, DRAIN. Registers: grant index g, last-served index, watchdog counter.
- IDLE: if any S_VALID, pick the first valid index searching from last-served+1 mod NIN. Register g, enter PKT. All S_READY are 0.
- PKT: S_READY[g] = !S_ABORT[g] && (!M_VALID || M_READY). Other S_READY = 0. Accepted beats load the output register.
  - Accepted beat with S_LAST[g]: return to IDLE at that edge; last-served <= g.
  - S_ABORT[g] after at least one beat has been accepted: M_ABORT pulses 1 cycle. M_VALID clears at the same edge, discarding any unaccepted pending beat. Go to IDLE; last-served <= g.
  - S_ABORT[g] before the first beat: go to IDLE silently (no M_ABORT); last-served <= g.
  - S_ABORT on non-granted inputs: ignored.
  - Watchdog: increments on every PKT cycle with S_VALID[g]=0 after the first beat. Clears on any accepted beat. At 2^LGTIMEOUT-1: M_ABORT pulse, o_timeout pulse, M_VALID cleared, enter DRAIN.
- DRAIN: S_READY[g]=1. Beats are discarded (never reach M_*). On an accepted beat with S_LAST[g], or on S_ABORT[g]: go to IDLE; last-served <= g.
- Reset (i_reset_n low, async): state IDLE, last-served = NIN-1 (input 0 wins first), watchdog 0. M_VALID, M_ABORT, M_DATA, M_BYTES, M_LAST, o_grant, o_timeout all 0. S_READY all 0.

## Timing
- Arbitration costs one cycle: S_VALID seen in IDLE at cycle 0 → S_READY[g] first possible at cycle 1 → M_VALID at cycle 2.
- Beat latency 1 cycle (registered). Sustained throughput 1 beat/cycle while M_READY=1.
- One dead (IDLE) cycle between consecutive packets, including back-to-back from the same source.
- M_VALID held with stable M_DATA/M_BYTES/M_LAST until M_READY. Never cleared by the arbiter except through the abort/timeout path.
- M_ABORT is registered, exactly one cycle wide, and never coincides with a newly loaded beat.
- S_LAST and S_ABORT on the same granted beat: abort wins (beat not accepted, M_ABORT if mid-packet).
- Reset mid-packet: outputs drop immediately (async). No M_ABORT is generated; downstream must be reset alongside.

## Test plan
- NIN=2, both sources present 3-beat packets continuously, M_READY=1 → output alternates 0,1,0,1. Each packet 3 consecutive M_VALID beats, 1 idle cycle between packets, o_grant one-hot matches source.
- Source 0 sends a 4-beat packet, source 1 raises VALID at beat 2 → source 1 waits. Its first beat appears on M_* 2 cycles after source 0's LAST is accepted.
- M_READY toggled 1,0,0,1 mid-packet → M_DATA stable during stall, no beat lost or duplicated, S_READY[g] low while the output is full and stalled.
- Source 0 aborts after beat 2 while beat 2 is stalled (M_READY=0) → M_VALID drops, M_ABORT=1 for one cycle, next grant goes to source 1.
- LGTIMEOUT=3: source 0 sends 1 beat then holds VALID low → after 7 stalled cycles o_timeout and M_ABORT pulse. The 3 remaining beats are drained (no M_VALID). Then IDLE.
- Async reset asserted mid-packet → all outputs 0 within the reset. After release, a simultaneous request from both sources grants input 0 first.
